// File: rtl/vga_timing_pattern.sv
// Parametrised VGA raster timing with a frame-synchronous RGB565 test-pattern source.
// All outputs are registered 1 clock after the counter state; no backpressure (free-running while en=1).
module vga_timing_pattern #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int X_W      = 11,
  parameter int Y_W      = 10,
  parameter int BAR_W    = 100,
  parameter int CHK_LOG2 = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [1:0]     mode,
  input  logic [15:0]    solid_color,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           frame_start,
  output logic [4:0]     red,
  output logic [5:0]     green,
  output logic [4:0]     blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BP_W    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [X_W-1:0] H_LAST     = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_ACT      = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] H_ACT_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [X_W-1:0] HS_FIRST   = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_LAST    = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [Y_W-1:0] V_LAST     = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_ACT      = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] V_ACT_LAST = Y_W'(V_ACTIVE - 1);
  localparam logic [Y_W-1:0] VS_FIRST   = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_LAST    = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [BP_W-1:0] BAR_LAST  = BP_W'(BAR_W - 1);

  logic [X_W-1:0]  h_cnt;
  logic [Y_W-1:0]  v_cnt;
  logic [1:0]      mode_q;
  logic [BP_W-1:0] bar_pix;
  logic [2:0]      bar_idx;

  logic        at_origin;
  logic        active;
  logic        h_wrap;
  logic [1:0]  cur_mode;
  logic [15:0] pix;

  always_comb begin
    at_origin = (h_cnt == '0) && (v_cnt == '0);
    h_wrap    = (h_cnt == H_LAST);
    active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    // The origin pixel already belongs to the new frame, so it uses the live mode input.
    cur_mode  = at_origin ? mode : mode_q;
    pix       = '0;
    case (cur_mode)
      2'd0: pix = solid_color;
      2'd1: pix = {{5{bar_idx[2]}}, {6{bar_idx[1]}}, {5{bar_idx[0]}}};
      2'd2: pix = (h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2]) ? 16'hFFFF : 16'h0000;
      default: pix = ((h_cnt[4:0] == 5'd0) || (v_cnt[4:0] == 5'd0) ||
                      (h_cnt == H_ACT_LAST) || (v_cnt == V_ACT_LAST)) ? 16'hFFFF : 16'h0000;
    endcase
    if (!active) pix = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      mode_q      <= '0;
      bar_pix     <= '0;
      bar_idx     <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else if (!en) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      bar_pix     <= '0;
      bar_idx     <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else begin
      if (h_wrap) begin
        h_cnt   <= '0;
        bar_pix <= '0;
        bar_idx <= '0;
        v_cnt   <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
        // Bar index tracks h_cnt/BAR_W incrementally and sticks at the last bar.
        if (bar_pix == BAR_LAST) begin
          bar_pix <= '0;
          if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_pix <= bar_pix + 1'b1;
        end
      end
      if (at_origin) mode_q <= mode;
      hsync       <= ((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST)) ? HS_POL : ~HS_POL;
      vsync       <= ((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST)) ? VS_POL : ~VS_POL;
      de          <= active;
      x           <= h_cnt;
      y           <= v_cnt;
      frame_start <= at_origin;
      red         <= pix[15:11];
      green       <= pix[10:5];
      blue        <= pix[4:0];
    end
  end

endmodule

// File: tb/tb_vga_timing_pattern.sv
// Bench for vga_timing_pattern: cycle model from raster arithmetic, pixel vector table, corner sequences.
module tb_vga_timing_pattern;

  localparam int HT = 24;
  localparam int VT = 12;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] solid_color = 16'h0000;
  logic        hsync, vsync, de, frame_start;
  logic [10:0] x;
  logic [9:0]  y;
  logic [4:0]  red;
  logic [5:0]  green;
  logic [4:0]  blue;
  logic [40:0] act;

  int checks = 0;
  int failures = 0;
  int k = 0;
  logic [1:0] mq = 2'd0;

  always #5 clk = ~clk;

  vga_timing_pattern #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .X_W(11), .Y_W(10),
    .BAR_W(2), .CHK_LOG2(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .solid_color(solid_color),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .frame_start(frame_start), .red(red), .green(green), .blue(blue)
  );

  assign act = {hsync, vsync, de, x, y, frame_start, red, green, blue};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [15:0] pat(input int h, input int v, input logic [1:0] m,
                                      input logic [15:0] sc);
    logic [2:0] i;
    if (h >= 16 || v >= 8) return 16'h0000;
    case (m)
      2'd0: return sc;
      2'd1: begin
        i = (h / 2 > 7) ? 3'd7 : 3'(h / 2);
        return {{5{i[2]}}, {6{i[1]}}, {5{i[0]}}};
      end
      2'd2: return ((((h >> 2) ^ (v >> 2)) & 1) != 0) ? 16'hFFFF : 16'h0000;
      default: return (h % 32 == 0 || v % 32 == 0 || h == 15 || v == 7) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  // One clock: predict outputs from the inputs present at this edge, then compare.
  task automatic step();
    logic [40:0] exp;
    int h, v;
    if (!en) begin
      exp = '0;
      k = 0;
    end else begin
      h = k % HT;
      v = (k / HT) % VT;
      if (k % FT == 0) mq = mode;
      exp = {(h >= 18 && h <= 20), (v >= 9 && v <= 10), (h < 16 && v < 8),
             11'(h), 10'(v), (h == 0 && v == 0), pat(h, v, mq, solid_color)};
      k++;
    end
    @(posedge clk);
    #1;
    check("cycle", {23'h0, act}, {23'h0, exp});
  endtask

  task automatic run_to(input int tx, input int ty);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      step();
      if (x == 11'(tx) && y == 10'(ty)) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach_xy", {63'h0, ok}, 64'h1);
  endtask

  typedef struct {
    string       name;
    logic [1:0]  m;
    logic [15:0] sc;
    int          px;
    int          py;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[14];
  int fs_gap, hs_c, vs_c, de_c, xmax, ymax;

  initial begin
    vecs[0]  = '{"bars_x0",   2'd1, 16'h0000, 0, 0,  16'h0000};
    vecs[1]  = '{"bars_x2",   2'd1, 16'h0000, 2, 0,  16'h001F};
    vecs[2]  = '{"bars_x4",   2'd1, 16'h0000, 4, 0,  16'h07E0};
    vecs[3]  = '{"bars_x8",   2'd1, 16'h0000, 8, 0,  16'hF800};
    vecs[4]  = '{"bars_x14",  2'd1, 16'h0000, 14, 0, 16'hFFFF};
    vecs[5]  = '{"bars_x16",  2'd1, 16'h0000, 16, 0, 16'h0000};
    vecs[6]  = '{"grid_0_5",  2'd3, 16'h0000, 0, 5,  16'hFFFF};
    vecs[7]  = '{"grid_15_3", 2'd3, 16'h0000, 15, 3, 16'hFFFF};
    vecs[8]  = '{"grid_3_7",  2'd3, 16'h0000, 3, 7,  16'hFFFF};
    vecs[9]  = '{"grid_5_5",  2'd3, 16'h0000, 5, 5,  16'h0000};
    vecs[10] = '{"chk_4_0",   2'd2, 16'h0000, 4, 0,  16'hFFFF};
    vecs[11] = '{"chk_4_4",   2'd2, 16'h0000, 4, 4,  16'h0000};
    vecs[12] = '{"solid_7_3", 2'd0, 16'h1234, 7, 3,  16'h1234};
    vecs[13] = '{"solid_7_9", 2'd0, 16'h1234, 7, 9,  16'h0000};

    // Reset state held over clock edges.
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {23'h0, act}, 64'h0);
    rst = 1'b0;
    step();

    // First frame_start and frame period.
    en = 1'b1;
    step();
    check("first_fs", {63'h0, frame_start}, 64'h1);
    fs_gap = 0;
    for (int i = 1; i <= 400; i++) begin
      step();
      if (frame_start) begin
        fs_gap = i;
        break;
      end
    end
    check("fs_period", 64'(fs_gap), 64'(FT));

    // Sync/de totals over one frame, starting at the observed origin pixel.
    hs_c = 0; vs_c = 0; de_c = 0; xmax = 0; ymax = 0;
    for (int i = 0; i < FT; i++) begin
      if (i != 0) step();
      hs_c += int'(hsync);
      vs_c += int'(vsync);
      de_c += int'(de);
      if (int'(x) > xmax) xmax = int'(x);
      if (int'(y) > ymax) ymax = int'(y);
    end
    check("hsync_cycles", 64'(hs_c), 64'(36));
    check("vsync_cycles", 64'(vs_c), 64'(48));
    check("de_cycles", 64'(de_c), 64'(128));
    check("x_max", 64'(xmax), 64'(23));
    check("y_max", 64'(ymax), 64'(11));

    // Pixel vector table: restart with the vector's mode, then read the pixel.
    foreach (vecs[i]) begin
      en = 1'b0;
      step();
      mode = vecs[i].m;
      solid_color = vecs[i].sc;
      en = 1'b1;
      run_to(vecs[i].px, vecs[i].py);
      check(vecs[i].name, {48'h0, red, green, blue}, {48'h0, vecs[i].exp});
    end

    // Mid-frame mode change must wait for the next frame.
    en = 1'b0;
    step();
    mode = 2'd0;
    solid_color = 16'hF800;
    en = 1'b1;
    run_to(0, 3);
    mode = 2'd2;
    run_to(4, 4);
    check("switch_same_frame", {48'h0, red, green, blue}, 64'hF800);
    run_to(4, 0);
    check("switch_next_4_0", {48'h0, red, green, blue}, 64'hFFFF);
    run_to(4, 4);
    check("switch_next_4_4", {48'h0, red, green, blue}, 64'h0000);

    // Asynchronous reset mid-frame, en low for 5 cycles, then restart.
    run_to(10, 4);
    check("pre_rst_xy", {43'h0, x, y}, {43'h0, 11'd10, 10'd4});
    rst = 1'b1;
    #2;
    check("async_rst", {23'h0, act}, 64'h0);
    en = 1'b0;
    @(posedge clk);
    #1;
    k = 0;
    mq = 2'd0;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    mode = 2'd3;
    en = 1'b1;
    step();
    check("restart_fs", {63'h0, frame_start}, 64'h1);
    check("restart_xy", {43'h0, x, y}, 64'h0);

    // Random mode/colour every cycle with occasional enable drops.
    for (int i = 0; i < 4 * FT; i++) begin
      mode = 2'($urandom_range(0, 3));
      solid_color = 16'($urandom);
      en = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
